// File: rtl/timer_pkg.sv
// Shared traffic-controller definitions used by the interval timer.
//   TIMER_WIDTH   : default bit width of the interval value and count
//   timer_state_e : IDLE / RUNNING state encoding
package timer_pkg;

    localparam int unsigned TIMER_WIDTH = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer.sv
// Interval timer: loads a length in seconds and pulses `expired` for one clk
// once that many one-second ticks have elapsed (a length of 0 acts as 1).
// Ports:
//   clk          : system clock, all state updates on the rising edge
//   Reset_Sync   : synchronous active-high reset (highest priority)
//   Value        : interval length, sampled only while start_timer is high
//   oneHz_enable : one-second tick enable, one tick per clk edge while high
//   start_timer  : level-sensitive load/restart, overrides the tick
//   expired      : registered one-clk pulse at the end of the interval
module timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             Reset_Sync,
    input  logic [WIDTH-1:0] Value,
    input  logic             oneHz_enable,
    input  logic             start_timer,
    output logic             expired
);

    timer_state_e     state;
    timer_state_e     state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             expired_next;

    // State, count and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            expired <= expired_next;
        end
    end

    // Next-state logic: a start always wins over a tick on the same edge.
    // A count of 0 or 1 ends the interval on the next tick, which is what
    // makes a loaded value of 0 behave like 1 and keeps the count from wrapping.
    always_comb begin
        state_next   = state;
        count_next   = count;
        expired_next = 1'b0;

        if (start_timer) begin
            count_next = Value;
            state_next = RUNNING;
        end else if (state == RUNNING && oneHz_enable) begin
            if (count > WIDTH'(1)) begin
                count_next = count - WIDTH'(1);
            end else begin
                count_next   = '0;
                expired_next = 1'b1;
                state_next   = IDLE;
            end
        end
    end

endmodule : timer

// File: tb/tb_timer.sv
// Self-checking bench for the interval timer: directed scenarios followed by
// randomized stimulus, all compared against a tick-counting reference model.
module tb_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         Reset_Sync;
    logic [W-1:0] Value;
    logic         oneHz_enable;
    logic         start_timer;
    logic         expired;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: whether an interval is active and how many ticks remain.
    bit   running      = 1'b0;
    int   remaining    = 0;
    logic exp_expired  = 1'b0;

    timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .Value        (Value),
        .oneHz_enable (oneHz_enable),
        .start_timer  (start_timer),
        .expired      (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one clk cycle of inputs, advance the model, check expired 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic [W-1:0] val, input logic tk);
        Reset_Sync   = rst;
        start_timer  = st;
        Value        = val;
        oneHz_enable = tk;
        @(posedge clk);
        exp_expired = 1'b0;
        if (rst) begin
            running   = 1'b0;
            remaining = 0;
        end else if (st) begin
            running   = 1'b1;
            remaining = (int'(val) == 0) ? 1 : int'(val);
        end else if (tk && running) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
                running     = 1'b0;
                exp_expired = 1'b1;
            end
        end
        #1;
        compared++;
        assert (expired === exp_expired)
        else begin
            mismatched++;
            $error("FAIL %s: expired observed=%b expected=%b", tag, expired, exp_expired);
        end
    endtask

    initial begin
        Reset_Sync   = 1'b1;
        start_timer  = 1'b0;
        Value        = '0;
        oneHz_enable = 1'b0;

        // Reset state
        step("reset", 1'b1, 1'b0, 4'd0, 1'b0);
        step("reset_hold", 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset wins over start; ticks afterwards never expire
        step("rst_vs_start", 1'b1, 1'b1, 4'd12, 1'b1);
        for (int i = 0; i < 15; i++) step("rst_idle_tick", 1'b0, 1'b0, 4'd12, 1'b1);

        // Value 12 with single-cycle ticks separated by idle cycles
        step("v12_start", 1'b0, 1'b1, 4'd12, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step("v12_tick", 1'b0, 1'b0, 4'd0, 1'b1);
            step("v12_gap", 1'b0, 1'b0, 4'd0, 1'b0);
        end
        step("v12_idle_tick", 1'b0, 1'b0, 4'd0, 1'b1);

        // Value 0 and Value 1 both expire on the first tick
        step("v0_start", 1'b0, 1'b1, 4'd0, 1'b0);
        step("v0_tick", 1'b0, 1'b0, 4'd0, 1'b1);
        step("v0_after", 1'b0, 1'b0, 4'd0, 1'b1);
        step("v1_start", 1'b0, 1'b1, 4'd1, 1'b0);
        step("v1_tick", 1'b0, 1'b0, 4'd0, 1'b1);
        step("v1_after", 1'b0, 1'b0, 4'd0, 1'b1);

        // Restart mid-interval discards the old count
        step("rs_start5", 1'b0, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 3; i++) step("rs_tick_old", 1'b0, 1'b0, 4'd0, 1'b1);
        step("rs_start4", 1'b0, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 5; i++) step("rs_tick_new", 1'b0, 1'b0, 4'd0, 1'b1);

        // Start and tick on the same edge: no decrement
        step("same_edge", 1'b0, 1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) step("same_edge_tick", 1'b0, 1'b0, 4'd0, 1'b1);

        // Holding start high keeps reloading and consumes no ticks
        for (int i = 0; i < 4; i++) step("start_held", 1'b0, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < 3; i++) step("start_held_tick", 1'b0, 1'b0, 4'd9, 1'b1);

        // Reset aborts an interval with no pulse
        step("abort_start", 1'b0, 1'b1, 4'd6, 1'b0);
        for (int i = 0; i < 2; i++) step("abort_tick", 1'b0, 1'b0, 4'd0, 1'b1);
        step("abort_reset", 1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) step("abort_after", 1'b0, 1'b0, 4'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic         r_rst;
            logic         r_st;
            logic         r_tk;
            logic [W-1:0] r_val;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 8);
            r_tk  = ($urandom_range(0, 99) < 45);
            r_val = W'($urandom);
            step("random", r_rst, r_st, r_val, r_tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_timer
